hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs_addr  in  REG_ADDR_W  ID source register 1.
- id_rt_addr  in  REG_ADDR_W  ID source register 2.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt (incl. store data).
- id_dst_addr  in  REG_ADDR_W  ID destination (rd/rt already selected).
- id_reg_write  in  1  ID instruction writes a register.
- id_is_load  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- fw_alu1  out  2  EX operand-A forward select: 00 none, 10 from EX/MEM, 01 from MEM/WB.
- fw_alu2  out  2  EX operand-B/store-data forward select, same encoding.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID register.
- flush_d  out  1  clear IF/ID register.
- flush_e  out  1  clear ID/EX register (bubble).
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-004 SHALL keep shadow records for EX, MEM, WB stages: valid, rs, rt, uses_rs, uses_rt, dst, reg_write, is_load.
REQ-005 SHALL advance ID->EX->MEM->WB records every cycle; EX record SHALL load a bubble (valid=0) when flush_e=1.
REQ-006 SHALL treat a record as a writer only if valid=1, reg_write=1 and dst!=0.
REQ-007 SHALL drive fw_alu1=10 when EX rs matches a MEM writer that is not a load; else 01 when it matches a WB writer; else 00; same rule for fw_alu2 with EX rt.
REQ-008 Forward outputs SHALL be combinational from the shadow records; EX/MEM SHALL take priority over MEM/WB.
REQ-009 SHALL assert load-use stall when id_valid=1 and an ID-used source equals dst of an EX writer with is_load=1.
REQ-010 On stall: stall_f=stall_d=flush_e=1, flush_d=0; duration exactly one cycle per load-use pair.
REQ-011 On ex_branch_taken=1: flush_d=flush_e=1, stall_f=stall_d=0; branch SHALL override a simultaneous stall.
REQ-012 stall_cnt SHALL increment by 1 each cycle stall_f=1 and saturate at all-ones.
REQ-013 Register 0 SHALL never cause forwarding or stall.

Reset
REQ-014 rst_n=0 SHALL immediately clear all shadow valid bits and stall_cnt; outputs SHALL read fw_alu1=fw_alu2=00, stall_f=stall_d=flush_d=flush_e=0.
REQ-015 Reset asserted mid-stall SHALL abort the stall; no stall SHALL follow release without a new hazard.

Configuration
REQ-016 With HAZARD_FWD_EN defined: forwarding per REQ-007..REQ-010.
REQ-017 Without HAZARD_FWD_EN: fw_alu1=fw_alu2=00 always; stall (REQ-010 outputs) SHALL persist while any ID-used source matches dst of an EX or MEM writer; WB write-before-read SHALL need no stall.

Structure
REQ-018 Forward-select encodings (FW_NONE=00, FW_EXM=10, FW_MWB=01) and the stage-record typedef SHALL live in the shared pipeline package, also used by the ALU.
REQ-019 One sub-module hazard_stage_reg SHALL hold a single stage record with flush input; instantiated three times.

Verification
REQ-020 add $3,$1,$2 then sub $4,$3,$5 -> sub in EX: fw_alu1=10, fw_alu2=00, no stall.
REQ-021 add $3 writer, one unrelated instr, then or $6,$7,$3 -> or in EX: fw_alu2=01.
REQ-022 lw $8 then add $9,$8,$8 -> one cycle stall_f=stall_d=flush_e=1, stall_cnt 0->1, then add in EX with fw_alu1=fw_alu2=01.
REQ-023 Load-use stall coincident with ex_branch_taken=1 -> flush_d=flush_e=1, stall_f=0, stall_cnt unchanged.
REQ-024 Writer with dst=$0 followed by reader of $0 -> fw 00, no stall; rst_n pulsed low mid-stall -> all outputs 0 immediately, stall_cnt=0.
REQ-025 Without HAZARD_FWD_EN: add $3 then sub $4,$3,$5 -> stall exactly two cycles, fw always 00.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared pipeline types, forward-select encodings and record helpers
package hazard_unit_pkg;
  localparam int REC_ADDR_W = 8;
  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_EXM  = 2'b10;
  localparam logic [1:0] FW_MWB  = 2'b01;
  // Addresses are zero-extended into fixed-width fields so one record type serves any REG_ADDR_W <= 8
  typedef struct packed {
    logic                  valid;
    logic [REC_ADDR_W-1:0] rs;
    logic [REC_ADDR_W-1:0] rt;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [REC_ADDR_W-1:0] dst;
    logic                  reg_write;
    logic                  is_load;
  } stage_rec_t;
  function automatic logic writes(input stage_rec_t w, input logic [REC_ADDR_W-1:0] a);
    return w.valid && w.reg_write && w.dst != '0 && w.dst == a;
  endfunction
  function automatic logic reads_from(input stage_rec_t w, input stage_rec_t r);
    return (r.uses_rs && writes(w, r.rs)) || (r.uses_rt && writes(w, r.rt));
  endfunction
  function automatic logic [1:0] fw_sel(input logic use_src, input logic [REC_ADDR_W-1:0] a,
                                        input stage_rec_t mem, input stage_rec_t wb);
    return !use_src ? FW_NONE : (writes(mem, a) && !mem.is_load) ? FW_EXM :
           writes(wb, a) ? FW_MWB : FW_NONE;
  endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline shadow record, flush loads a bubble
module hazard_stage_reg
  import hazard_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  stage_rec_t d,
  output stage_rec_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= flush ? '0 : d;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use stall and branch flush for a 5-stage pipeline.
// HAZARD_FWD_EN enables forwarding; without it every RAW on EX/MEM writers stalls.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fw_alu1,
  output logic [1:0]            fw_alu2,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_W-1:0]      stall_cnt
);
  stage_rec_t id_rec, ex, mem, wb;
  logic hazard, br, stall, unused_rec;
  assign id_rec = '{valid: id_valid, rs: REC_ADDR_W'(id_rs_addr), rt: REC_ADDR_W'(id_rt_addr),
                    uses_rs: id_uses_rs, uses_rt: id_uses_rt, dst: REC_ADDR_W'(id_dst_addr),
                    reg_write: id_reg_write, is_load: id_is_load};
  hazard_stage_reg u_ex  (.clk(clk), .rst_n(rst_n), .flush(flush_e), .d(id_rec), .q(ex));
  hazard_stage_reg u_mem (.clk(clk), .rst_n(rst_n), .flush(1'b0),    .d(ex),     .q(mem));
  hazard_stage_reg u_wb  (.clk(clk), .rst_n(rst_n), .flush(1'b0),    .d(mem),    .q(wb));
`ifdef HAZARD_FWD_EN
  assign fw_alu1 = fw_sel(ex.valid && ex.uses_rs, ex.rs, mem, wb);
  assign fw_alu2 = fw_sel(ex.valid && ex.uses_rt, ex.rt, mem, wb);
  assign hazard  = id_valid && ex.is_load && reads_from(ex, id_rec);
`else
  assign fw_alu1 = FW_NONE;
  assign fw_alu2 = FW_NONE;
  // WB writes before ID reads, so only EX and MEM writers block
  assign hazard  = id_valid && (reads_from(ex, id_rec) || reads_from(mem, id_rec));
`endif
  assign unused_rec = ^{ex, mem, wb};
  assign br      = rst_n && ex_branch_taken;
  assign stall   = hazard && !br;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_d = br;
  assign flush_e = br || stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven directed check of hazard_unit, both HAZARD_FWD_EN builds
module tb_hazard_unit;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int NS = FWD ? 1 : 2;
  localparam logic [7:0] Z = 8'h00, ST = 8'h0D, BR = 8'h03;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load, ex_branch_taken;
  logic [4:0] id_rs_addr, id_rt_addr, id_dst_addr;
  logic [1:0] fw_alu1, fw_alu2;
  logic stall_f, stall_d, flush_d, flush_e;
  logic [2:0] stall_cnt;
  always #5 clk = ~clk;
  hazard_unit #(.REG_ADDR_W(5), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .fw_alu1(fw_alu1), .fw_alu2(fw_alu2),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_cnt(stall_cnt));
  typedef struct {
    logic v; logic [4:0] rs, rt; logic ur, ut; logic [4:0] dst; logic rw, ld, br;
    logic [7:0] e;
  } vec_t;
  vec_t tbl[$];
  int n_vec = 0, n_err = 0, exp_cnt = 0;
  function automatic vec_t mk(logic v, int rs, int rt, logic ur, logic ut, int dst,
                              logic rw, logic ld, logic br, logic [7:0] e);
    vec_t t;
    t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.ur = ur; t.ut = ut; t.dst = 5'(dst);
    t.rw = rw; t.ld = ld; t.br = br; t.e = e;
    return t;
  endfunction
  function automatic vec_t op(int rs, int rt, int dst, logic [7:0] e, logic br = 1'b0);
    return mk(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, br, e);
  endfunction
  function automatic vec_t lw(int base, int dst, logic [7:0] e);
    return mk(1'b1, base, 0, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0, e);
  endfunction
  function automatic vec_t nop(logic [7:0] e);
    return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, e);
  endfunction
  task automatic check(string nm, logic [7:0] e);
    logic [7:0] got;
    got = {fw_alu1, fw_alu2, stall_f, stall_d, flush_d, flush_e};
    n_vec++;
    if (got !== e || stall_cnt !== 3'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s: got fw1/fw2/sf/sd/fd/fe=%b cnt=%0d, want %b cnt=%0d",
               nm, got, stall_cnt, e, exp_cnt);
    end
  endtask
  task automatic step(vec_t t, string nm);
    @(negedge clk);
    id_valid = t.v; id_rs_addr = t.rs; id_rt_addr = t.rt; id_uses_rs = t.ur;
    id_uses_rt = t.ut; id_dst_addr = t.dst; id_reg_write = t.rw; id_is_load = t.ld;
    ex_branch_taken = t.br;
    #1 check(nm, t.e);
    if (t.e[3] && exp_cnt < 7) exp_cnt++;
  endtask
  initial begin
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_dst_addr = 0; id_reg_write = 0; id_is_load = 0; ex_branch_taken = 1;
    #1 check("reset", Z);
    ex_branch_taken = 0;
    @(negedge clk) rst_n = 1;
`ifdef HAZARD_FWD_EN
    tbl.push_back(op(1, 2, 3, Z));      tbl.push_back(op(3, 5, 4, Z));
    tbl.push_back(nop(8'h80));          tbl.push_back(op(1, 2, 3, Z));
    tbl.push_back(op(11, 12, 10, Z));   tbl.push_back(op(7, 3, 6, Z));
    tbl.push_back(nop(8'h10));          tbl.push_back(lw(1, 8, Z));
    tbl.push_back(op(8, 8, 9, ST));     tbl.push_back(op(8, 8, 9, Z));
    tbl.push_back(nop(8'h50));          tbl.push_back(lw(1, 8, Z));
    tbl.push_back(op(8, 8, 9, BR, 1'b1)); tbl.push_back(nop(Z));
    tbl.push_back(op(1, 2, 0, Z));      tbl.push_back(op(0, 0, 5, Z));
    tbl.push_back(nop(Z));              tbl.push_back(lw(1, 0, Z));
    tbl.push_back(op(0, 0, 9, Z));      tbl.push_back(op(1, 2, 3, Z));
    tbl.push_back(op(4, 5, 3, Z));      tbl.push_back(op(3, 3, 6, Z));
    tbl.push_back(nop(8'hA0));          tbl.push_back(nop(Z));
`else
    tbl.push_back(op(1, 2, 3, Z));      tbl.push_back(op(3, 5, 4, ST));
    tbl.push_back(op(3, 5, 4, ST));     tbl.push_back(op(3, 5, 4, Z));
    tbl.push_back(nop(Z));              tbl.push_back(op(1, 2, 3, Z));
    tbl.push_back(op(11, 12, 10, Z));   tbl.push_back(op(7, 3, 6, ST));
    tbl.push_back(op(7, 3, 6, Z));      tbl.push_back(nop(Z));
    tbl.push_back(lw(1, 8, Z));         tbl.push_back(op(8, 8, 9, ST));
    tbl.push_back(op(8, 8, 9, ST));     tbl.push_back(op(8, 8, 9, Z));
    tbl.push_back(nop(Z));              tbl.push_back(op(1, 2, 3, Z));
    tbl.push_back(op(3, 5, 4, BR, 1'b1)); tbl.push_back(nop(Z));
    tbl.push_back(op(1, 2, 0, Z));      tbl.push_back(op(0, 0, 5, Z));
    tbl.push_back(nop(Z));
`endif
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
    step(lw(1, 8, Z), "rst_lw");
    step(op(8, 8, 9, ST), "rst_stall");
    #1 rst_n = 0;
    exp_cnt = 0;
    #1 check("rst_abort", Z);
    @(negedge clk) rst_n = 1;
    #1 check("rst_release", Z);
    step(op(8, 8, 9, Z), "rst_quiet");
    for (int p = 0; p < 9; p++) begin
      step(lw(1, 8, (FWD && p > 0) ? 8'h50 : Z), $sformatf("sat_lw%0d", p));
      for (int k = 0; k < NS; k++) step(op(8, 8, 9, ST), $sformatf("sat_stall%0d_%0d", p, k));
      step(op(8, 8, 9, Z), $sformatf("sat_go%0d", p));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
